// File: rtl/uart_comm_mc_pkg.sv
// Shared definitions for the uart_comm_mc transceiver slice.
//   - parity mode codes (PARITY parameter values)
//   - FSM state type shared by the TX and RX state machines
//   - bit positions inside the sticky err_status vector
package uart_comm_mc_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int ERR_PAR = 0;
  localparam int ERR_FRM = 1;
  localparam int ERR_OVR = 2;

endpackage

// File: rtl/uart_comm_mc_if.sv
// CPU-side byte bus of uart_comm_mc.
//   send_flag/send_data : push into TX FIFO
//   recv_flag/recv_data : pop RX FIFO head (first-word fall-through)
//   sendable/receivable : TX not full / RX not empty
//   tx_busy             : frame on the Tx line
//   err_status/err_clr  : sticky {overrun, frame, parity} and its clear
// master = CPU side, slave = UART side.
interface uart_comm_mc_if #(
  parameter int DATA_BITS = 8
);
  logic                 send_flag;
  logic [DATA_BITS-1:0] send_data;
  logic                 recv_flag;
  logic [DATA_BITS-1:0] recv_data;
  logic                 sendable;
  logic                 receivable;
  logic                 tx_busy;
  logic [2:0]           err_status;
  logic                 err_clr;

  modport master (
    output send_flag, send_data, recv_flag, err_clr,
    input  recv_data, sendable, receivable, tx_busy, err_status
  );

  modport slave (
    input  send_flag, send_data, recv_flag, err_clr,
    output recv_data, sendable, receivable, tx_busy, err_status
  );
endinterface

// File: rtl/uart_comm_mc_fifo.sv
// uart_fifo: synchronous FIFO with first-word fall-through read port.
//   CLK, RST_N      : clock, asynchronous active-low reset
//   wr_en, wr_data  : push (ignored while full)
//   rd_en, rd_data  : pop (ignored while empty); rd_data shows the head,
//                     and reads as zero while the FIFO is empty
//   full, empty     : status, derived from pointers carrying an extra MSB
module uart_fifo #(
  parameter int DATA_L = 8,
  parameter int ADDR_L = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wr_en,
  input  logic [DATA_L-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_L-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  logic [DATA_L-1:0] mem [2**ADDR_L];
  logic [ADDR_L:0]   wr_ptr;
  logic [ADDR_L:0]   rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_L] != rd_ptr[ADDR_L]) &&
                 (wr_ptr[ADDR_L-1:0] == rd_ptr[ADDR_L-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign rd_data = empty ? '0 : mem[rd_ptr[ADDR_L-1:0]];

  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr[ADDR_L-1:0]] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_comm_mc.sv
// uart_comm_mc: parametrised UART transceiver with TX/RX FIFOs.
//   CLK, RST_N : system clock, asynchronous active-low reset
//   bus        : uart_comm_mc_if.slave CPU byte bus (push/pop, flags, errors)
//   Tx         : serial out, idle high
//   Rx         : serial in, asynchronous (2-flop synchronised)
//   loopback   : only with UART_LOOPBACK_EN defined; when high the receiver
//                listens to the internal Tx line and the Tx pin is held high
// Frame: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
// With SIM defined, sent/received bytes are reported tagged with ID.
module uart_comm_mc
  import uart_comm_mc_pkg::*;
#(
  parameter int ID          = 1,
  parameter int BAUDRATE    = 9600,
  parameter int CLOCKRATE   = 100000000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_ADDR_L = 5
) (
  input  logic            CLK,
  input  logic            RST_N,
  uart_comm_mc_if.slave   bus,
  output logic            Tx,
  input  logic            Rx
`ifdef UART_LOOPBACK_EN
  ,
  input  logic            loopback
`endif
);

  localparam int BIT_CYC = CLOCKRATE / BAUDRATE;
  localparam int BC_W    = $clog2(BIT_CYC);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BIT_CYC - 1);
  localparam logic [BC_W-1:0] BC_HALF = BC_W'(BIT_CYC / 2 - 1);
  localparam logic [3:0] DB_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] DB_ALL  = 4'(DATA_BITS);
  localparam logic PAR_ODD = (PARITY == PARITY_ODD);
  localparam bit   HAS_PAR = (PARITY != PARITY_NONE);

  // ---------------------------------------------------------------- FIFOs
  logic                 tx_full, tx_empty, tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_full, rx_empty, rx_push;
  logic [DATA_BITS-1:0] rx_byte;

  uart_fifo #(.DATA_L(DATA_BITS), .ADDR_L(FIFO_ADDR_L)) u_tx_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .wr_en   (bus.send_flag),
    .wr_data (bus.send_data),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  uart_fifo #(.DATA_L(DATA_BITS), .ADDR_L(FIFO_ADDR_L)) u_rx_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .wr_en   (rx_push),
    .wr_data (rx_byte),
    .rd_en   (bus.recv_flag),
    .rd_data (bus.recv_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  assign bus.sendable   = !tx_full;
  assign bus.receivable = !rx_empty;

  // -------------------------------------------------------------- Tx path
  logic [BC_W-1:0]      baud_cnt;
  logic                 tick;
  uart_state_e          tx_state;
  logic [DATA_BITS-1:0] tx_shreg;
  logic [3:0]           tx_bitcnt;
  logic                 tx_par;
  logic                 tx_stop2;
  logic                 tx_line;
  logic                 tx_busy_r;
  logic                 tx_last_stop;

  assign tick = (baud_cnt == '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                baud_cnt <= '0;
    else if (baud_cnt == BC_LAST) baud_cnt <= '0;
    else                       baud_cnt <= baud_cnt + 1'b1;
  end

  assign tx_last_stop = (tx_state == ST_STOP) && ((STOP_BITS == 1) || tx_stop2);
  // Loading straight out of the last stop bit keeps frames back-to-back.
  assign tx_pop = tick && !tx_empty && ((tx_state == ST_IDLE) || tx_last_stop);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state  <= ST_IDLE;
      tx_shreg  <= '0;
      tx_bitcnt <= '0;
      tx_par    <= 1'b0;
      tx_stop2  <= 1'b0;
      tx_line   <= 1'b1;
      tx_busy_r <= 1'b0;
    end else if (tick) begin
      if (tx_pop) begin
        tx_shreg  <= tx_head;
        tx_par    <= (^tx_head) ^ PAR_ODD;
        tx_stop2  <= 1'b0;
        tx_line   <= 1'b0;
        tx_busy_r <= 1'b1;
        tx_state  <= ST_START;
`ifdef SIM
        $display("uart_comm_mc %0d: tx %h", ID, tx_head);
`endif
      end else begin
        unique case (tx_state)
          ST_IDLE: ;
          ST_START: begin
            tx_line   <= tx_shreg[0];
            tx_shreg  <= tx_shreg >> 1;
            tx_bitcnt <= 4'd1;
            tx_state  <= ST_DATA;
          end
          ST_DATA: begin
            if (tx_bitcnt == DB_ALL) begin
              if (HAS_PAR) begin
                tx_line  <= tx_par;
                tx_state <= ST_PARITY;
              end else begin
                tx_line  <= 1'b1;
                tx_state <= ST_STOP;
              end
            end else begin
              tx_line   <= tx_shreg[0];
              tx_shreg  <= tx_shreg >> 1;
              tx_bitcnt <= tx_bitcnt + 4'd1;
            end
          end
          ST_PARITY: begin
            tx_line  <= 1'b1;
            tx_state <= ST_STOP;
          end
          ST_STOP: begin
            if (tx_last_stop) begin
              tx_line   <= 1'b1;
              tx_busy_r <= 1'b0;
              tx_state  <= ST_IDLE;
            end else begin
              tx_stop2 <= 1'b1;
            end
          end
          default: tx_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.tx_busy = tx_busy_r;

  // ------------------------------------------------------- line selection
  logic rx_in;
`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? tx_line : Rx;
  assign Tx    = loopback ? 1'b1 : tx_line;
`else
  assign rx_in = Rx;
  assign Tx    = tx_line;
`endif

  // -------------------------------------------------------------- Rx path
  logic [1:0]           rx_sync;
  logic                 rx_s;
  uart_state_e          rx_state;
  logic [BC_W-1:0]      rx_cnt;
  logic [3:0]           rx_bitcnt;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_par_bad;
  logic                 rx_sample;
  logic                 rx_par_exp;
  logic [2:0]           err_set;
  logic [2:0]           err_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rx_sync <= '1;
    else        rx_sync <= {rx_sync[0], rx_in};
  end
  assign rx_s = rx_sync[1];

  // First sample lands mid start bit, later ones a full bit apart.
  assign rx_sample  = (rx_state == ST_START) ? (rx_cnt == BC_HALF) : (rx_cnt == BC_LAST);
  assign rx_par_exp = (^rx_shreg) ^ PAR_ODD;

  always_comb begin
    err_set = '0;
    if (rx_sample) begin
      if ((rx_state == ST_PARITY) && (rx_s != rx_par_exp)) err_set[ERR_PAR] = 1'b1;
      if (rx_state == ST_STOP) begin
        if (!rx_s)                       err_set[ERR_FRM] = 1'b1;
        else if (!rx_par_bad && rx_full) err_set[ERR_OVR] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_state   <= ST_IDLE;
      rx_cnt     <= '0;
      rx_bitcnt  <= '0;
      rx_shreg   <= '0;
      rx_par_bad <= 1'b0;
      rx_push    <= 1'b0;
      rx_byte    <= '0;
    end else begin
      rx_push <= 1'b0;
      if (rx_state != ST_IDLE) rx_cnt <= rx_sample ? '0 : rx_cnt + 1'b1;
      unique case (rx_state)
        ST_IDLE: begin
          if (!rx_s) begin
            rx_cnt     <= '0;
            rx_par_bad <= 1'b0;
            rx_state   <= ST_START;
          end
        end
        ST_START: begin
          if (rx_sample) begin
            rx_bitcnt <= '0;
            rx_state  <= rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (rx_sample) begin
            rx_shreg <= {rx_s, rx_shreg[DATA_BITS-1:1]};
            if (rx_bitcnt == DB_LAST) rx_state <= HAS_PAR ? ST_PARITY : ST_STOP;
            else                      rx_bitcnt <= rx_bitcnt + 4'd1;
          end
        end
        ST_PARITY: begin
          if (rx_sample) begin
            rx_par_bad <= (rx_s != rx_par_exp);
            rx_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (rx_sample) begin
            rx_state <= ST_IDLE;
            if (rx_s && !rx_par_bad && !rx_full) begin
              rx_push <= 1'b1;
              rx_byte <= rx_shreg;
`ifdef SIM
              $display("uart_comm_mc %0d: rx %h", ID, rx_shreg);
`endif
            end
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // A fresh error outranks a simultaneous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)           err_q <= '0;
    else if (bus.err_clr) err_q <= err_set;
    else                  err_q <= err_q | err_set;
  end

  assign bus.err_status = err_q;

endmodule

// File: doc/uart_comm_mc.md
Name: uart_comm_mc

Overview:
- Parametrised successor UART transceiver. Configurable data width, parity mode, stop bits and FIFO depth.
- Fully synchronous FIFO handshakes with sticky error reporting.
- Sits between the CPU-side I/O bus (byte push/pop, level-style flags) and the board Tx/Rx pins.
- One instance per serial port; `ID` tags simulation messages.

Parameters:
- ID, 1, instance tag used in simulation `$display` messages
- BAUDRATE, 9600, line bit rate
- CLOCKRATE, 100000000, CLK frequency in Hz; BIT_CYC = CLOCKRATE/BAUDRATE, must be >= 4
- DATA_BITS, 8, payload bits per frame, legal 5..8, LSB first
- PARITY, 1, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, legal 1 or 2
- FIFO_ADDR_L, 5, log2 of TX and RX FIFO depth (depth 32)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- send_flag  in  1  push send_data into TX FIFO this cycle
- send_data  in  DATA_BITS  byte to transmit
- recv_flag  in  1  pop RX FIFO head this cycle
- recv_data  out  DATA_BITS  RX FIFO head, first-word fall-through
- sendable  out  1  TX FIFO not full
- receivable  out  1  RX FIFO not empty
- tx_busy  out  1  frame currently on Tx
- err_status  out  3  sticky {overrun, frame, parity}
- err_clr  in  1  clear err_status
- Tx  out  1  serial out, idle high
- Rx  in  1  serial in, asynchronous

Behaviour:
- Reset (RST_N low, asynchronous): Tx=1, both FIFOs empty, recv_data=0, sendable=1, receivable=0, tx_busy=0, err_status=0, both FSMs IDLE, Rx synchroniser flops=1.
- FIFO push/pop:
  - send_flag while full: ignored, no state change.
  - recv_flag while empty: ignored.
  - Push and pop in the same cycle on a non-empty FIFO: count unchanged.
  - Pointers wrap modulo 2^FIFO_ADDR_L; full/empty come from an extra pointer MSB.
- Rx path:
  - 2-flop synchroniser feeds an rx_s signal.
  - RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE->START on rx_s==0; bit counter cleared.
  - Sample point at count==BIT_CYC/2-1, then every BIT_CYC cycles.
  - START: rx_s==1 at the sample point = glitch, return to IDLE; otherwise go to DATA.
  - DATA: shift DATA_BITS samples LSB first.
  - PARITY: state skipped when PARITY==0. Mismatch sets err_status[0]; the byte is still discarded.
  - STOP: samples only the first stop bit. rx_s==0 sets err_status[1] and drops the byte.
  - Good byte and RX FIFO full: set err_status[2], drop the byte. Otherwise push one cycle after the stop sample.
  - Return to IDLE immediately after the stop sample. A new start bit can be detected from the next cycle.
- Tx path:
  - Free-running baud counter, 0..BIT_CYC-1; transitions happen only at count==0.
  - TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE, TX FIFO non-empty at tick: pop into the shift register, Tx=0, tx_busy=1, go to START.
  - Each subsequent tick drives the next bit: DATA_BITS data bits, then parity (if PARITY != 0), then STOP_BITS ones.
  - After the last stop bit go to IDLE with tx_busy=0. The next frame may start on the following tick, giving back-to-back frames with no gap.
  - Parity: even = XOR of data bits; odd = its inverse.
- err_status:
  - Bits are sticky.
  - err_clr clears them.
  - If err_clr and a new error happen in the same cycle, the new error wins (bit stays set).
- Width: send_data and recv_data are exactly DATA_BITS wide, with no padding.
- Simulation: in SIM, `$display` of ID plus the byte when a frame is sent or received.

Optional Feature:
- UART_LOOPBACK_EN:
  - Defined: adds input port `loopback` (1 bit). When high, the RX synchroniser input is Tx instead of Rx, and the Tx pin is held at 1.
  - Not defined: no `loopback` port; Rx always drives the receiver.

Decomposition:
- Shared package/header `uart_defs`:
  - PARITY_NONE/EVEN/ODD codes.
  - FSM state encodings ST_IDLE/ST_START/ST_DATA/ST_PARITY/ST_STOP.
  - Error bit indices ERR_PAR=0, ERR_FRM=1, ERR_OVR=2.
- One sub-module `uart_fifo` (params DATA_L, ADDR_L). It has synchronous read/write, first-word fall-through, full/empty, and asynchronous active-low reset. It is instantiated twice.

Test Plan (CLOCKRATE=1600, BAUDRATE=100, so BIT_CYC=16):
- Loopback, 8E1: push 0xA5 -> Tx sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 16 cycles; receivable rises; recv_data=0xA5; err_status=0.
- Drive Rx with 0x3C, wrong parity -> err_status=3'b001, receivable stays 0. Then err_clr -> err_status=0.
- Drive Rx 0x55 with stop bit=0 -> err_status=3'b010, no push. A 3-cycle low glitch on Rx -> no frame, no error.
- Fill the RX FIFO with 32 frames, then send a 33rd -> err_status[2]=1; the first 32 bytes pop in order; receivable=0 after 32 pops.
- Push 33 bytes into the TX FIFO with no pops -> sendable=0 after 32; the 33rd is ignored. Frames go out back-to-back with no idle gap.
- Assert RST_N low mid-frame -> Tx=1 and tx_busy=0 immediately (asynchronously); FIFOs empty; the next frame after release transmits correctly.
